div_ctrl: RTL and testbench

Multi-cycle 32-bit integer divide sequencer for the EX stage. Accepts a divide request from EX, runs a 32-iteration restoring trial-subtraction datapath, and drives `ex_stall_o` into the pipeline stall controller's `ex_stall` input, freezing PC, IF/ID, ID and EX until the quotient/remainder pair is ready for HI/LO write-back. It also supports signed/unsigned operation, divide-by-zero short-circuit, and annulment on pipeline flush.

---
 rtl/div_pkg.sv | 11 +
 rtl/div_ctrl_if.sv | 21 ++
 rtl/div_step.sv | 31 +++
 rtl/div_ctrl.sv | 102 ++++++++++
 tb/tb_div_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divide sequencer: FSM encodings and iteration count.
package div_pkg;
  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_BUSY = 2'b10,
    DIV_END  = 2'b11
  } div_state_t;
endpackage

// File: rtl/div_ctrl_if.sv
// EX <-> divider handshake bundle; master is the EX stage, slave is div_ctrl.
interface div_ctrl_if #(parameter int WIDTH = 32);
  logic               start_i;
  logic               annul_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               ex_stall_o;

  modport master (
    output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, ex_stall_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, ex_stall_o
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and shift the outcome into the quotient.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // quo holds the not-yet-consumed dividend bits in its upper part, so its MSB
  // is the next bit to bring down. When the trial fits, the difference is below
  // the divisor and therefore fits in WIDTH bits.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisor});
    diff    = shifted[WIDTH-1:0] - divisor;
    if (fits) begin
      rem_next = diff;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divide sequencer for the EX stage; stalls the
// pipeline while iterating and presents {remainder, quotient} for HI/LO.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input logic      clk,
  input logic      reset,
  div_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  div_state_t         state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [WIDTH-1:0]   rem_reg, quo_reg, div_reg;
  logic [WIDTH-1:0]   rem_next, quo_next;
  logic               neg_quo_reg, neg_rem_reg;
  logic [2*WIDTH-1:0] result_reg;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               go;

  assign a_neg = bus.signed_i & bus.opdata1_i[WIDTH-1];
  assign b_neg = bus.signed_i & bus.opdata2_i[WIDTH-1];
  assign a_mag = a_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign b_mag = b_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
  assign go    = bus.start_i & ~bus.annul_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (div_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= DIV_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DIV_IDLE: if (go) state_next = (bus.opdata2_i == '0) ? DIV_ZERO : DIV_BUSY;
      DIV_ZERO: state_next = bus.annul_i ? DIV_IDLE : DIV_END;
      DIV_BUSY: begin
        if (bus.annul_i)                 state_next = DIV_IDLE;
        else if (count_reg == LAST_ITER) state_next = DIV_END;
      end
      DIV_END:  if (bus.annul_i || !bus.start_i) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Operands and sign flags are re-latched every IDLE cycle, so anything driven
  // on opdata*_i after the divide has left IDLE is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg   <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_reg     <= '0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_reg  <= '0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          count_reg   <= '0;
          rem_reg     <= '0;
          quo_reg     <= a_mag;
          div_reg     <= b_mag;
          neg_quo_reg <= a_neg ^ b_neg;
          neg_rem_reg <= a_neg;
        end
        DIV_ZERO: if (!bus.annul_i) result_reg <= '0;
        DIV_BUSY: if (!bus.annul_i) begin
          rem_reg   <= rem_next;
          quo_reg   <= quo_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_ITER) begin
            result_reg <= {neg_rem_reg ? (~rem_next + 1'b1) : rem_next,
                           neg_quo_reg ? (~quo_next + 1'b1) : quo_next};
          end
        end
        default: ;
      endcase
    end
  end

  // Stall is combinational so the pipeline freezes in the very cycle the divide
  // arrives in EX; it is forced low while reset is held.
  assign bus.ex_stall_o = reset & (((state_reg == DIV_IDLE) & go) |
                                   (state_reg == DIV_ZERO) |
                                   (state_reg == DIV_BUSY));
  assign bus.ready_o    = (state_reg == DIV_END);
  assign bus.result_o   = result_reg;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, stall window, signed fixups, divide by
// zero, annulment and mid-operation reset.
module tb_div_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  div_ctrl_if #(.WIDTH(32)) dif ();

  div_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  // Samples once per cycle at negedge+1 until ready_o is seen or the budget runs out.
  // Operands are inverted at cycle 5 to confirm they are not re-sampled.
  task automatic wait_done(output int lat, output int stalls);
    lat = -1;
    stalls = 0;
    for (int c = 0; c < 80; c++) begin
      if (dif.ready_o) begin
        lat = c;
        break;
      end
      if (dif.ex_stall_o) stalls++;
      if (c == 5) begin
        dif.opdata1_i = ~dif.opdata1_i;
        dif.opdata2_i = ~dif.opdata2_i;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp_res, input int exp_lat);
    int lat, stalls;
    @(negedge clk);
    dif.opdata1_i = a;
    dif.opdata2_i = b;
    dif.signed_i  = sgn;
    dif.start_i   = 1'b1;
    #1;
    wait_done(lat, stalls);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (stalls !== exp_lat) begin
      failures++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_lat);
    end
    checks++;
    if (dif.result_o !== exp_res || dif.ex_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL %s result: got %h stall=%b expected %h stall=0",
               name, dif.result_o, dif.ex_stall_o, exp_res);
    end
    // start still held: must remain in END with the result intact
    @(negedge clk); #1;
    checks++;
    if (dif.ready_o !== 1'b1 || dif.result_o !== exp_res) begin
      failures++;
      $display("FAIL %s hold_end: got ready=%b result=%h expected ready=1 result=%h",
               name, dif.ready_o, dif.result_o, exp_res);
    end
    dif.start_i = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (dif.ready_o !== 1'b0 || dif.ex_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL %s back_to_idle: got ready=%b stall=%b expected 0 0",
               name, dif.ready_o, dif.ex_stall_o);
    end
    $display("div %s a=%h b=%h signed=%b -> result=%h latency=%0d", name, a, b, sgn,
             dif.result_o, lat);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    dif.signed_i = 1'b0;
    dif.opdata1_i = '0;
    dif.opdata2_i = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dif.result_o !== 64'd0 || dif.ready_o !== 1'b0 || dif.ex_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got result=%h ready=%b stall=%b expected 0 0 0",
               dif.result_o, dif.ready_o, dif.ex_stall_o);
    end
    @(negedge clk);
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_unsigned();
    run_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    run_div("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, 33);
  endtask

  task automatic test_signed();
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
  endtask

  task automatic test_div_zero();
    run_div("u_zero", 32'd5, 32'd0, 1'b0, 64'd0, 2);
    run_div("pre", 32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 33);
    run_div("s_zero", 32'hFFFF_FFFB, 32'd0, 1'b1, 64'd0, 2);
  endtask

  task automatic test_annul();
    logic [63:0] prev;
    int ready_seen;
    run_div("pre_annul", 32'd50, 32'd6, 1'b0, {32'd2, 32'd8}, 33);
    prev = dif.result_o;
    // annul in IDLE must suppress the stall and the start
    @(negedge clk);
    dif.opdata1_i = 32'd1;
    dif.opdata2_i = 32'd1;
    dif.start_i = 1'b1;
    dif.annul_i = 1'b1;
    #1;
    checks++;
    if (dif.ex_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_annul_stall: got %b expected 0", dif.ex_stall_o);
    end
    @(negedge clk);
    dif.annul_i = 1'b0;
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd3;
    #1;
    // start now honoured: cycle 0 of the divide to be annulled
    repeat (10) @(negedge clk);
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    dif.annul_i = 1'b0;
    #1;
    checks++;
    if (dif.ex_stall_o !== 1'b0 || dif.ready_o !== 1'b0 || dif.result_o !== prev) begin
      failures++;
      $display("FAIL annul_idle: got stall=%b ready=%b result=%h expected 0 0 %h",
               dif.ex_stall_o, dif.ready_o, dif.result_o, prev);
    end
    ready_seen = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (dif.ready_o) ready_seen++;
    end
    checks++;
    if (ready_seen !== 0 || dif.result_o !== prev) begin
      failures++;
      $display("FAIL annul_no_ready: got ready_cycles=%0d result=%h expected 0 %h",
               ready_seen, dif.result_o, prev);
    end
    $display("annul at cycle 10: stall=%b ready_cycles=%0d", dif.ex_stall_o, ready_seen);
    run_div("post_annul", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33);
  endtask

  task automatic test_reset_mid();
    int lat, stalls;
    @(negedge clk);
    dif.opdata1_i = 32'd77;
    dif.opdata2_i = 32'd10;
    dif.signed_i = 1'b0;
    dif.start_i = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (dif.result_o !== 64'd0 || dif.ready_o !== 1'b0 || dif.ex_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got result=%h ready=%b stall=%b expected 0 0 0",
               dif.result_o, dif.ready_o, dif.ex_stall_o);
    end
    repeat (2) @(negedge clk);
    dif.opdata1_i = 32'd77;
    dif.opdata2_i = 32'd10;
    reset = 1'b1;
    #1;
    wait_done(lat, stalls);
    checks++;
    if (lat !== 33 || stalls !== 33 || dif.result_o !== {32'd7, 32'd7}) begin
      failures++;
      $display("FAIL reset_restart: got lat=%0d stalls=%0d result=%h expected 33 33 %h",
               lat, stalls, dif.result_o, {32'd7, 32'd7});
    end
    $display("reset mid-divide then restart: latency=%0d result=%h", lat, dif.result_o);
    dif.start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
